// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-way (video/CPU/DMA) arbiter and sequencer for an 8-bit SRAM port
// Optional feature macro: SRAM_ARB_RR_EN (round-robin CPU/DMA sharing; default fixed CPU>DMA)
module sram_arbiter #(
  parameter int WAIT = 2,
  parameter int AW   = 18
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vreq,
  input  logic [AW-1:0] va,
  output logic          vack,
  output logic [7:0]    vq,
  input  logic          creq,
  input  logic          cwe,
  input  logic [AW-1:0] ca,
  input  logic [7:0]    cd,
  output logic          cack,
  output logic [7:0]    cq,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] da,
  input  logic [7:0]    dd,
  output logic          dack,
  output logic [7:0]    dq,
  output logic          ramRd,
  output logic          ramWr,
  output logic [AW-1:0] ramA,
  output logic [7:0]    ramD,
  input  logic [7:0]    ramQ,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACT = 2'd1, FIN = 2'd2} state_t;

  localparam logic [1:0] OWN_V = 2'd0;
  localparam logic [1:0] OWN_C = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state_q, state_d;
  logic [1:0]    owner_q;
  logic          we_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] rama_q;
  logic [7:0]    ramd_q;
  logic [7:0]    vq_q, cq_q, dq_q;
  logic          any_req;
  logic          c_win;
  logic          d_win;
  logic          last_cycle;

  assign any_req    = vreq | creq | dreq;
  assign last_cycle = (cnt_q == 4'd1);

`ifdef SRAM_ARB_RR_EN
  // rr_q set means DMA won the last CPU/DMA slot, so CPU takes the next tie
  logic rr_q;
  assign c_win = creq & (~dreq | rr_q);
`else
  assign c_win = creq;
`endif
  assign d_win = dreq & ~c_win;

  // State register; reset aborts any in-flight access
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: requests only matter in IDLE; ACT runs WAIT cycles; FIN is the ack cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACT;
      ACT:     if (last_cycle) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latching, wait counter and read-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN_C;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rama_q  <= '0;
      ramd_q  <= 8'h00;
      vq_q    <= 8'hFF;
      cq_q    <= 8'hFF;
      dq_q    <= 8'hFF;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= WAIT_CNT;
          if (vreq) begin
            owner_q <= OWN_V;
            we_q    <= 1'b0;
            rama_q  <= va;
          end else if (c_win) begin
            owner_q <= OWN_C;
            we_q    <= cwe;
            rama_q  <= ca;
            if (cwe) ramd_q <= cd;
          end else if (d_win) begin
            owner_q <= OWN_D;
            we_q    <= dwe;
            rama_q  <= da;
            if (dwe) ramd_q <= dd;
          end
        end
        ACT: begin
          cnt_q <= cnt_q - 4'd1;
          if (last_cycle && !we_q) begin
            case (owner_q)
              OWN_V:   vq_q <= ramQ;
              OWN_C:   cq_q <= ramQ;
              default: dq_q <= ramQ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin pointer tracks the last non-video winner
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= 1'b1;
    end else if (state_q == IDLE && !vreq) begin
      if (c_win)      rr_q <= 1'b0;
      else if (d_win) rr_q <= 1'b1;
    end
  end
`endif

  // Outputs decoded from state: strobes during ACT, owner's ack during FIN
  always_comb begin
    ramRd = 1'b0;
    ramWr = 1'b0;
    vack  = 1'b0;
    cack  = 1'b0;
    dack  = 1'b0;
    busy  = (state_q != IDLE);
    if (state_q == ACT) begin
      ramRd = ~we_q;
      ramWr = we_q;
    end
    if (state_q == FIN) begin
      vack = (owner_q == OWN_V);
      cack = (owner_q == OWN_C);
      dack = (owner_q == OWN_D);
    end
  end

  assign ramA = rama_q;
  assign ramD = ramd_q;
  assign vq   = vq_q;
  assign cq   = cq_q;
  assign dq   = dq_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  localparam int AW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          vreq, creq, dreq;
  logic          cwe, dwe;
  logic [AW-1:0] va, ca, da;
  logic [7:0]    cd, dd;
  logic          vack, cack, dack;
  logic [7:0]    vq, cq, dq;
  logic          ramRd, ramWr, busy;
  logic [AW-1:0] ramA;
  logic [7:0]    ramD, ramQ;

  int checks = 0;
  int errors = 0;

  // SRAM model: read data depends on the low address byte
  assign ramQ = ramA[7:0] ^ 8'h5A;

  always #5 clock = ~clock;

  sram_arbiter #(.WAIT(2), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .vreq(vreq), .va(va), .vack(vack), .vq(vq),
    .creq(creq), .cwe(cwe), .ca(ca), .cd(cd), .cack(cack), .cq(cq),
    .dreq(dreq), .dwe(dwe), .da(da), .dd(dd), .dack(dack), .dq(dq),
    .ramRd(ramRd), .ramWr(ramWr), .ramA(ramA), .ramD(ramD), .ramQ(ramQ),
    .busy(busy)
  );

  task tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task test_reset;
    reset = 1'b1;
    vreq = 0; creq = 0; dreq = 0; cwe = 0; dwe = 0;
    va = '0; ca = '0; da = '0; cd = 8'h00; dd = 8'h00;
    tick; tick;
    reset = 1'b0;
    tick;
    checks++; if ({ramRd, ramWr, busy} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b exp 000", {ramRd, ramWr, busy}); end
    checks++; if ({vack, cack, dack} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b exp 000", {vack, cack, dack}); end
    checks++; if (ramA !== 18'h0 || ramD !== 8'h00) begin errors++; $display("FAIL reset_ram_bus: got A=%h D=%h exp 0/00", ramA, ramD); end
    checks++; if ({vq, cq, dq} !== 24'hFFFFFF) begin errors++; $display("FAIL reset_q: got %h exp ffffff", {vq, cq, dq}); end
  endtask

  task test_cpu_read;
    creq = 1; cwe = 0; ca = 18'h04000;
    tick;
    checks++; if (ramRd !== 1'b1 || ramWr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_t1: got rd=%b wr=%b busy=%b exp 1 0 1", ramRd, ramWr, busy); end
    checks++; if (ramA !== 18'h04000) begin errors++; $display("FAIL rd_addr: got %h exp 04000", ramA); end
    tick;
    checks++; if (ramRd !== 1'b1 || cack !== 1'b0) begin errors++; $display("FAIL rd_t2: got rd=%b cack=%b exp 1 0", ramRd, cack); end
    tick;
    checks++; if (cack !== 1'b1 || ramRd !== 1'b0) begin errors++; $display("FAIL rd_t3_ack: got cack=%b rd=%b exp 1 0", cack, ramRd); end
    checks++; if (cq !== 8'h5A) begin errors++; $display("FAIL rd_cq: got %h exp 5a", cq); end
    creq = 0;
    tick;
    checks++; if (busy !== 1'b0 || cack !== 1'b0 || cq !== 8'h5A) begin errors++; $display("FAIL rd_t4: got busy=%b cack=%b cq=%h exp 0 0 5a", busy, cack, cq); end
  endtask

  task test_cpu_write;
    creq = 1; cwe = 1; ca = 18'h1FFFF; cd = 8'hA5;
    for (int k = 1; k <= 2; k++) begin
      tick;
      checks++; if (ramWr !== 1'b1 || ramRd !== 1'b0) begin errors++; $display("FAIL wr_strobe_c%0d: got wr=%b rd=%b exp 1 0", k, ramWr, ramRd); end
      checks++; if (ramA !== 18'h1FFFF || ramD !== 8'hA5) begin errors++; $display("FAIL wr_bus_c%0d: got A=%h D=%h exp 1ffff a5", k, ramA, ramD); end
    end
    tick;
    checks++; if (ramWr !== 1'b0 || cack !== 1'b1 || ramRd !== 1'b0) begin errors++; $display("FAIL wr_end: got wr=%b cack=%b rd=%b exp 0 1 0", ramWr, cack, ramRd); end
    checks++; if (ramA !== 18'h1FFFF || ramD !== 8'hA5) begin errors++; $display("FAIL wr_hold: got A=%h D=%h exp 1ffff a5", ramA, ramD); end
    creq = 0; cwe = 0;
    tick;
    checks++; if (cack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_after: got cack=%b busy=%b exp 0 0", cack, busy); end
  endtask

  task test_simultaneous;
    int vt, ct, dt;
    vt = 0; ct = 0; dt = 0;
    vreq = 1; va = 18'h00011;
    creq = 1; cwe = 0; ca = 18'h00022;
    dreq = 1; dwe = 0; da = 18'h00033;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (vack && vt == 0) begin vt = k; vreq = 0; end
      if (cack && ct == 0) begin ct = k; creq = 0; end
      if (dack && dt == 0) begin dt = k; dreq = 0; end
    end
    vreq = 0; creq = 0; dreq = 0;
    checks++; if (vt !== 3) begin errors++; $display("FAIL sim_vack_time: got %0d exp 3", vt); end
    checks++; if (ct !== 7) begin errors++; $display("FAIL sim_cack_time: got %0d exp 7", ct); end
    checks++; if (dt !== 11) begin errors++; $display("FAIL sim_dack_time: got %0d exp 11", dt); end
    checks++; if ({vq, cq, dq} !== 24'h4B7869) begin errors++; $display("FAIL sim_q: got %h exp 4b7869", {vq, cq, dq}); end
  endtask

  task test_round_robin;
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) seq[i] = 2'd0;
`ifdef SRAM_ARB_RR_EN
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2;
`else
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1; exp_seq[3] = 2'd1;
`endif
    reset = 1; tick; reset = 0;
    creq = 1; cwe = 0; ca = 18'h00001;
    dreq = 1; dwe = 0; da = 18'h00002;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick;
      if (cack && dack) begin seq[n] = 2'd3; n++; end
      else if (cack) begin seq[n] = 2'd1; n++; end
      else if (dack) begin seq[n] = 2'd2; n++; end
    end
    creq = 0; dreq = 0;
    tick;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order_%0d: got %0d exp %0d (1=cpu 2=dma)", i, seq[i], exp_seq[i]); end
    end
  endtask

  task test_reset_abort;
    int dcount;
    dcount = 0;
    dreq = 1; dwe = 1; da = 18'h00100; dd = 8'h3C;
    tick;
    checks++; if (ramWr !== 1'b1) begin errors++; $display("FAIL abort_act1: got wr=%b exp 1", ramWr); end
    tick;
    checks++; if (ramWr !== 1'b1) begin errors++; $display("FAIL abort_act2: got wr=%b exp 1", ramWr); end
    reset = 1;
    tick;
    checks++; if (ramWr !== 1'b0 || busy !== 1'b0 || dack !== 1'b0) begin errors++; $display("FAIL abort_forced_idle: got wr=%b busy=%b dack=%b exp 0 0 0", ramWr, busy, dack); end
    checks++; if ({vq, cq, dq} !== 24'hFFFFFF) begin errors++; $display("FAIL abort_q_reload: got %h exp ffffff", {vq, cq, dq}); end
    reset = 0;
    tick;
    checks++; if (ramWr !== 1'b1 || ramA !== 18'h00100 || ramD !== 8'h3C) begin errors++; $display("FAIL abort_restart: got wr=%b A=%h D=%h exp 1 00100 3c", ramWr, ramA, ramD); end
    for (int k = 0; k < 3; k++) begin
      tick;
      if (dack) begin dcount++; dreq = 0; end
    end
    dreq = 0; dwe = 0;
    checks++; if (dcount !== 1) begin errors++; $display("FAIL abort_dack_count: got %0d exp 1", dcount); end
  endtask

  task test_video_preempt;
    int vt, dt;
    vt = 0; dt = 0;
    creq = 1; cwe = 0; ca = 18'h00040;
    dreq = 1; dwe = 0; da = 18'h00050;
    tick;
    checks++; if (ramRd !== 1'b1 || ramA !== 18'h00040) begin errors++; $display("FAIL pre_cpu_act: got rd=%b A=%h exp 1 00040", ramRd, ramA); end
    vreq = 1; va = 18'h00060;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (cack) creq = 0;
      if (vack && vt == 0) begin vt = k; vreq = 0; end
      if (dack && dt == 0) begin dt = k; dreq = 0; end
    end
    vreq = 0; creq = 0; dreq = 0;
    checks++; if (vt !== 6) begin errors++; $display("FAIL pre_vack_time: got %0d exp 6", vt); end
    checks++; if (dt !== 10) begin errors++; $display("FAIL pre_dack_time: got %0d exp 10", dt); end
    checks++; if (vq !== 8'h3A || dq !== 8'h0A) begin errors++; $display("FAIL pre_q: got vq=%h dq=%h exp 3a 0a", vq, dq); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_cpu_read;
    test_cpu_write;
    test_simultaneous;
    test_round_robin;
    test_reset_abort;
    test_video_preempt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
